instruction_fetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 14 +
 rtl/if_id_register.sv | 33 +++
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the pipelined MIPS datapath.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       NOP_WORD   = 32'h0000_0000;  // sll $0,$0,0
    localparam word_t       RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS = 128;
    localparam word_t       PC_INCR    = 32'd4;
    localparam word_t       IMEM_BYTES = word_t'(IMEM_WORDS * 4);

    typedef enum logic [0:0] {RUN, HALT} fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Flush inserts a bubble and wins over hold.
module if_id_register
    import mips_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset,
    input  logic  hold,
    input  logic  flush,
    input  word_t next_instruction,
    input  word_t next_pc_plus4,
    output word_t instruction,
    output word_t pc_plus4,
    output logic  valid
);

    // Capture, hold or bubble the fetched instruction.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instruction <= NOP_WORD;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP_WORD;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (!hold) begin
            instruction <= next_instruction;
            pc_plus4    <= next_pc_plus4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM and IF/ID register.
// Optional macro IMEM_BOUNDS_CHECK_EN adds a Fault output and a HALT state
// entered when a fetch is attempted outside instruction memory.
module instruction_fetch_unit
    import mips_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset,
    input  word_t Instruction,
    input  logic  Stall,
    input  logic  Redirect,
    input  word_t RedirectTarget,
    output word_t Address,
    output word_t IfId_Instruction,
    output word_t IfId_PCPlus4,
    output logic  IfId_Valid,
    output word_t FetchCount
`ifdef IMEM_BOUNDS_CHECK_EN
    ,
    output logic  Fault
`endif
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        count_q, count_d;
    word_t        pc_plus4;
    logic         hold;
    logic         flush;

    assign pc_plus4   = pc_q + PC_INCR;
    assign Address    = pc_q;
    assign FetchCount = count_q;
`ifdef IMEM_BOUNDS_CHECK_EN
    assign Fault = (state_q == HALT);
`endif

    // Next-state logic: Redirect > Stall > normal fetch; HALT freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        hold    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (Redirect) begin
                    pc_d  = {RedirectTarget[31:2], 2'b00};
                    flush = 1'b1;
                end else if (Stall) begin
                    hold = 1'b1;
                end else begin
`ifdef IMEM_BOUNDS_CHECK_EN
                    if (pc_q >= IMEM_BYTES) begin
                        state_d = HALT;
                        flush   = 1'b1;
                    end else
`endif
                    begin
                        pc_d    = pc_plus4;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            HALT: begin
                hold = 1'b1;
            end
            default: begin
                hold = 1'b1;
            end
        endcase
    end

    // PC, fetch counter and FSM state registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_register u_if_id_register (
        .Clk              (Clk),
        .Reset            (Reset),
        .hold             (hold),
        .flush            (flush),
        .next_instruction (Instruction),
        .next_pc_plus4    (pc_plus4),
        .instruction      (IfId_Instruction),
        .pc_plus4         (IfId_PCPlus4),
        .valid            (IfId_Valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory holds mem[i] = i*3.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] Address;
    logic [31:0] IfId_Instruction;
    logic [31:0] IfId_PCPlus4;
    logic        IfId_Valid;
    logic [31:0] FetchCount;
`ifdef IMEM_BOUNDS_CHECK_EN
    logic        Fault;
`endif

    logic [31:0] mem [128];
    int          tests_run    = 0;
    int          tests_failed = 0;

    always #5 Clk = ~Clk;

    assign Instruction = mem[Address[8:2]];

    instruction_fetch_unit dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Instruction      (Instruction),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .Address          (Address),
        .IfId_Instruction (IfId_Instruction),
        .IfId_PCPlus4     (IfId_PCPlus4),
        .IfId_Valid       (IfId_Valid),
        .FetchCount       (FetchCount)
`ifdef IMEM_BOUNDS_CHECK_EN
        ,
        .Fault            (Fault)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid, input logic [31:0] count);
        check({tag, ".addr"},  Address,          addr);
        check({tag, ".instr"}, IfId_Instruction, instr);
        check({tag, ".pc4"},   IfId_PCPlus4,     pc4);
        check({tag, ".valid"}, {31'd0, IfId_Valid}, {31'd0, valid});
        check({tag, ".count"}, FetchCount,       count);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = i * 3;
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = '0;
        #2;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        Reset = 1'b1;

        step(); check_ifid("fetch0", 32'd4, 32'd0, 32'd4, 1'b1, 32'd1);
        step(); check_ifid("fetch1", 32'd8, 32'd3, 32'd8, 1'b1, 32'd2);

        Stall = 1'b1;
        step(); check_ifid("stall0", 32'd8, 32'd3, 32'd8, 1'b1, 32'd2);
        step(); check_ifid("stall1", 32'd8, 32'd3, 32'd8, 1'b1, 32'd2);
        Stall = 1'b0;
        step(); check_ifid("unstall", 32'd12, 32'd6, 32'd12, 1'b1, 32'd3);

        Redirect = 1'b1; RedirectTarget = 32'h0000_0043;
        step(); check_ifid("redir", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
        Redirect = 1'b0;
        step(); check_ifid("after_redir", 32'h44, 32'd48, 32'h44, 1'b1, 32'd4);

        Redirect = 1'b1; Stall = 1'b1; RedirectTarget = 32'h20;
        step(); check_ifid("redir_stall", 32'h20, 32'h0, 32'h0, 1'b0, 32'd4);
        Redirect = 1'b0; Stall = 1'b0;
        step(); check_ifid("after_rs", 32'h24, 32'd24, 32'h24, 1'b1, 32'd5);

        // Asynchronous reset between edges.
        #2 Reset = 1'b0;
        #1 check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        #1 Reset = 1'b1;
        step(); check_ifid("post_rst", 32'd4, 32'd0, 32'd4, 1'b1, 32'd1);

`ifdef IMEM_BOUNDS_CHECK_EN
        check("fault_idle", {31'd0, Fault}, 32'd0);
        Redirect = 1'b1; RedirectTarget = 32'h200;
        step(); check_ifid("oob_redir", 32'h200, 32'h0, 32'h0, 1'b0, 32'd1);
        check("fault_pre", {31'd0, Fault}, 32'd0);
        Redirect = 1'b0;
        step(); check_ifid("fault", 32'h200, 32'h0, 32'h0, 1'b0, 32'd1);
        check("fault_set", {31'd0, Fault}, 32'd1);
        Redirect = 1'b1; RedirectTarget = 32'h0;
        step(); check_ifid("halt_redir", 32'h200, 32'h0, 32'h0, 1'b0, 32'd1);
        Redirect = 1'b0; Stall = 1'b1;
        step(); check("halt_stall", {31'd0, Fault}, 32'd1);
        Stall = 1'b0;
        #2 Reset = 1'b0;
        #1 check("fault_clr", {31'd0, Fault}, 32'd0);
        check("fault_clr.addr", Address, 32'h0);
        #1 Reset = 1'b1;
`else
        // PC wraps modulo 2^32; memory aliases on Address[8:2].
        Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFF;
        step(); check_ifid("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd1);
        Redirect = 1'b0;
        step(); check_ifid("wrap", 32'h0, 32'd381, 32'h0, 1'b1, 32'd2);
        Redirect = 1'b1; RedirectTarget = 32'h0000_0204;
        step();
        Redirect = 1'b0;
        step(); check_ifid("alias", 32'h208, 32'd3, 32'h208, 1'b1, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
